// File: rtl/zdet_stream_scheduler_pkg.sv
// Shared types and constants for the z-detector stream scheduler.
package zdet_pkg;

    localparam int REQ_N = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RST   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    typedef enum logic [2:0] {
        A = 3'd0,
        B = 3'd1,
        C = 3'd2,
        D = 3'd3,
        E = 3'd4
    } det_state_t;

endpackage

// File: rtl/zdet_stream_scheduler_if.sv
// Requester-side bus of the scheduler: level requests, frames, grant, result.
interface zdet_stream_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    import zdet_pkg::*;

    logic [REQ_N-1:0] req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [REQ_N-1:0] gnt;
    logic             done;
    logic             done_id;
    logic [CNT_W-1:0] zcount;

    modport master (output req, data0, data1, input gnt, done, done_id, zcount);
    modport slave  (input req, data0, data1, output gnt, done, done_id, zcount);

endinterface

// File: rtl/zdet_stream_scheduler_model.sv
// 5-state Moore pattern detector with synchronous reset; z is high in D and E.
// state | meaning
// A     | reset / waiting for first 1
// B     | one 1 seen
// C     | recovering after D on a 1
// D     | 1,1,0 seen (z=1)
// E     | 1,1 seen (z=1)
module zdet_model
    import zdet_pkg::*;
(
    input  logic clk,
    input  logic det_rst,
    input  logic x,
    output logic z
);

    det_state_t r_state;

    // Next-state transitions; det_rst forces A on the clock edge.
    always_ff @(posedge clk) begin
        if (det_rst) begin
            r_state <= A;
        end else begin
            case (r_state)
                A:       r_state <= x ? B : A;
                B:       r_state <= x ? E : B;
                C:       r_state <= x ? B : C;
                D:       r_state <= x ? C : B;
                E:       r_state <= x ? E : D;
                default: r_state <= A;
            endcase
        end
    end

    assign z = (r_state == D) || (r_state == E);

endmodule

// File: rtl/zdet_stream_scheduler.sv
// Round-robin scheduler that serialises frames into a shared z-detector and
// returns the number of z-high samples per frame.
// Build option: define ZDET_INTERNAL_EN to use an internal zdet_model instead
// of the z port (x and det_rst ports are driven the same either way).
// state | meaning
// IDLE  | waiting for a request; winner chosen and frame latched on exit
// RST   | one-cycle grant, detector held in reset
// SHIFT | WIDTH cycles driving x LSB first, z summed from the second cycle
// DONE  | final z sample added, done pulse with result
module zdet_stream_scheduler
    import zdet_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   resetn,
    zdet_stream_scheduler_if.slave bus,
    output logic                   det_rst,
    output logic                   x,
    input  logic                   z
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RST   = RST;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]       r_state;
    logic             r_id;
    logic             r_last_gnt;
    logic [WIDTH-1:0] r_shreg;
    logic [IDX_W-1:0] r_bit_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_zcount;

    logic             w_z;
    logic             w_win;
    logic             w_first;
    logic [CNT_W-1:0] w_sum;

`ifdef ZDET_INTERNAL_EN
    logic w_z_int;

    zdet_model u_det (
        .clk     (clk),
        .det_rst (det_rst),
        .x       (x),
        .z       (w_z_int)
    );

    assign w_z = w_z_int;
`else
    assign w_z = z;
`endif

    // Sole requester wins; on a tie the one not granted last time wins.
    assign w_win   = bus.req[1] & (~bus.req[0] | ~r_last_gnt);
    assign w_first = (r_bit_rem == LAST_IDX);
    assign w_sum   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt
                                              : r_cnt + {{(CNT_W-1){1'b0}}, w_z};

    // Sequencer: arbitration, frame shift-out and z accumulation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_id       <= 1'b0;
            r_last_gnt <= 1'b1;
            r_shreg    <= '0;
            r_bit_rem  <= '0;
            r_cnt      <= '0;
            r_zcount   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        r_state    <= ST_RST;
                        r_id       <= w_win;
                        r_last_gnt <= w_win;
                        r_shreg    <= w_win ? bus.data1 : bus.data0;
                        r_cnt      <= '0;
                        r_bit_rem  <= LAST_IDX;
                    end
                end
                ST_RST: begin
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_shreg <= r_shreg >> 1;
                    if (!w_first) begin
                        r_cnt <= w_sum;
                    end
                    if (r_bit_rem == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_bit_rem <= r_bit_rem - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_cnt    <= w_sum;
                    r_zcount <= w_sum;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt     = (r_state == ST_RST) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.done    = (r_state == ST_DONE);
    assign bus.done_id = r_id;
    // The DONE-cycle result includes the sample taken in that cycle.
    assign bus.zcount  = (r_state == ST_DONE) ? w_sum : r_zcount;
    assign det_rst     = ~resetn | (r_state == ST_RST);
    assign x           = (r_state == ST_SHIFT) & r_shreg[0];

endmodule

// File: tb/tb_zdet_stream_scheduler.sv
// Directed bench for zdet_stream_scheduler; zdet_model acts as the detector.
module tb_zdet_stream_scheduler;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic resetn;
    logic det_rst;
    logic x;
    logic z;
    logic w_z_model;

    int checks   = 0;
    int failures = 0;

    zdet_stream_scheduler_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_if ();

    zdet_stream_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (u_if),
        .det_rst (det_rst),
        .x       (x),
        .z       (z)
    );

    zdet_model u_det (
        .clk     (clk),
        .det_rst (det_rst),
        .x       (x),
        .z       (w_z_model)
    );

`ifdef ZDET_INTERNAL_EN
    assign z = 1'b1;
`else
    assign z = w_z_model;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame from an IDLE negedge through the idle cycle after done.
    task automatic do_frame(input logic [1:0] rq, input logic [7:0] d0, input logic [7:0] d1,
                            input logic eid, input int ecnt, input bit drop, input bit perturb);
        logic [7:0] f;
        int n;
        f = eid ? d1 : d0;
        u_if.req   = rq;
        u_if.data0 = d0;
        u_if.data1 = d1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (u_if.gnt === 2'b00 && n < 20);
        chk("grant_latency", n, 1);
        chk("gnt_onehot", u_if.gnt, eid ? 2'b10 : 2'b01);
        chk("det_rst_in_rst", det_rst, 1'b1);
        chk("x_in_rst", x, 1'b0);
        if (drop) u_if.req = 2'b00;
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            chk("x_bit", x, f[k]);
            chk("gnt_in_shift", u_if.gnt, 2'b00);
            chk("det_rst_in_shift", det_rst, 1'b0);
            chk("done_early", u_if.done, 1'b0);
            if (perturb) begin
                u_if.data0 = ~u_if.data0;
                u_if.req   = (k >= 5) ? 2'b00 : (k[0] ? 2'b10 : 2'b11);
            end
        end
        @(negedge clk);
        chk("done_pulse", u_if.done, 1'b1);
        chk("zcount", u_if.zcount, ecnt);
        chk("done_id", u_if.done_id, eid);
        chk("x_in_done", x, 1'b0);
        @(negedge clk);
        chk("done_cleared", u_if.done, 1'b0);
        chk("idle_gap_gnt", u_if.gnt, 2'b00);
        chk("zcount_hold", u_if.zcount, ecnt);
    endtask

    initial begin
        int n;
        resetn     = 1'b0;
        u_if.req   = 2'b00;
        u_if.data0 = '0;
        u_if.data1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", u_if.gnt, 2'b00);
        chk("rst_x", x, 1'b0);
        chk("rst_done", u_if.done, 1'b0);
        chk("rst_done_id", u_if.done_id, 1'b0);
        chk("rst_zcount", u_if.zcount, 0);
        chk("rst_det_rst", det_rst, 1'b1);
        resetn = 1'b1;

        do_frame(2'b01, 8'h0B, 8'h00, 1'b0, 2, 1'b1, 1'b0);
        do_frame(2'b10, 8'h00, 8'hFF, 1'b1, 7, 1'b1, 1'b0);
        do_frame(2'b01, 8'h00, 8'h00, 1'b0, 0, 1'b1, 1'b0);
        do_frame(2'b01, 8'h0B, 8'h00, 1'b0, 2, 1'b1, 1'b1);

        // Abort a frame with reset while bit 4 (a 1) is on x.
        u_if.req   = 2'b01;
        u_if.data0 = 8'h10;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (u_if.gnt === 2'b00 && n < 20);
        chk("abort_gnt", u_if.gnt, 2'b01);
        u_if.req = 2'b00;
        repeat (5) @(negedge clk);
        chk("abort_x_before", x, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("abort_gnt_after", u_if.gnt, 2'b00);
        chk("abort_x_after", x, 1'b0);
        chk("abort_done_after", u_if.done, 1'b0);
        chk("abort_det_rst", det_rst, 1'b1);
        u_if.req   = 2'b11;
        u_if.data0 = 8'h0B;
        u_if.data1 = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", u_if.done, 1'b0);
        end
        resetn = 1'b1;

        // Both requests held from reset: strict alternation starting at 0.
        do_frame(2'b11, 8'h0B, 8'hFF, 1'b0, 2, 1'b0, 1'b0);
        do_frame(2'b11, 8'h0B, 8'hFF, 1'b1, 7, 1'b0, 1'b0);
        do_frame(2'b11, 8'h0B, 8'hFF, 1'b0, 2, 1'b0, 1'b0);
        do_frame(2'b11, 8'h0B, 8'hFF, 1'b1, 7, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zdet_stream_scheduler.md
Name: zdet_stream_scheduler

Overview:
- Controller and arbiter for a shared serial pattern-detector channel (the 5-state Moore FSM: input x, output z).
- Two requesters submit WIDTH-bit frames. The block arbitrates round-robin and drives the detector's synchronous reset and serial input x, LSB first.
- It counts the cycles in which the detector's z is high over the frame and returns that count with a one-cycle done pulse.

Parameters:
- WIDTH, 8, frame length in bits (>=2).
- CNT_W, $clog2(WIDTH+1), width of zcount.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- req  in  2  level request per requester; held until own gnt bit seen.
- data0  in  WIDTH  frame for requester 0; sampled on the grant edge.
- data1  in  WIDTH  frame for requester 1; sampled on the grant edge.
- gnt  out  2  one-hot, high for exactly one cycle (the RST cycle).
- det_rst  out  1  synchronous reset to detector.
- x  out  1  serial bit to detector.
- z  in  1  detector Moore output.
- done  out  1  one-cycle pulse; zcount/done_id valid only this cycle.
- done_id  out  1  requester index of the finished frame.
- zcount  out  CNT_W  number of z-high samples in the frame.

Behaviour:
- Reset (resetn=0, async): state=IDLE, gnt=0, x=0, done=0, done_id=0, zcount=0, bit index=0, last_gnt=1 (requester 0 wins first tie). det_rst=1 while resetn=0.
- States:
  - IDLE: any req high at clock edge -> RST. Pick the winner: sole requester, or if both high, the one != last_gnt. Latch its data into the shift register, set last_gnt and the id, clear the count.
  - RST (1 cycle): gnt[id]=1, det_rst=1, x=0 -> SHIFT.
  - SHIFT (WIDTH cycles, k=0..WIDTH-1): det_rst=0, x=shreg[k]. In cycles k>=1, add z to the count -> DONE after k=WIDTH-1.
  - DONE (1 cycle): add z to the count (final sample, reflecting the detector state after the last bit). Assert done with the final zcount value (combinational sum or registered equivalent; the visible value must include this sample) and done_id -> IDLE. A new request is not accepted until the next IDLE edge, so there is a minimum 1 idle cycle between frames.
- Latency: done rises exactly WIDTH+1 cycles after the gnt cycle. Exactly WIDTH z samples are taken per frame.
- Output values outside active states:
  - x=0 outside SHIFT.
  - det_rst=0 outside RST and reset.
  - zcount holds its last value outside DONE; consumers qualify it with done.
- Requests arriving or dropping during RST/SHIFT/DONE are ignored. The data inputs are not re-sampled mid-frame.
- Async reset mid-frame aborts immediately:
  - no done pulse;
  - last_gnt returns to 1.
- The count saturates at its maximum representable value. The saturation can only matter if CNT_W is overridden smaller than the default.

Optional Feature:
- ZDET_INTERNAL_EN defined: instantiate an internal detector model driven by det_rst/x.
  - Its z replaces the port z, which is ignored.
  - The x and det_rst ports are still driven identically.
- Undefined: z comes from the port. No detector logic is present.

Decomposition:
- Package zdet_pkg contains:
  - the state enum (IDLE, RST, SHIFT, DONE);
  - the detector state enum (A..E);
  - the constant REQ_N=2.
- Sub-module zdet_model: 5-state Moore detector with synchronous reset.
  - A: x?B:A
  - B: x?E:B
  - C: x?B:C
  - D: x?C:B
  - E: x?E:D
  - z=(D|E)
  - Used under ZDET_INTERNAL_EN and reused by the bench as the detector.

Test Plan:
- req=01, data0=8'h0B: bits 1,1,0,1,0,0,0,0 give z samples 0,1,1,0,0,0,0,0. Expect gnt=01 for one cycle, zcount=2, done_id=0, done 9 cycles after gnt.
- req=10, data1=8'hFF: expect zcount=7, done_id=1. req=01, data0=8'h00: expect zcount=0.
- req=11 held continuously from reset: grant order 0,1,0,1. Each gnt is one cycle, and there is >=1 IDLE cycle between done and the next gnt.
- Assert resetn=0 during SHIFT k=4: expect gnt/x/done=0 immediately and det_rst=1. After release with req=11, requester 0 is granted first.
- Toggle data0 and req during SHIFT: expect x to follow the latched frame, zcount unchanged versus the clean run (2 for 8'h0B).
- Build with ZDET_INTERNAL_EN and port z tied to 1: repeat the first scenario and expect zcount=2.
